// File: rtl/raddr_responder.sv
// rtl/raddr_responder.sv - AXI4 read-slave responder serving AR bursts from a local SRAM
// AR queue feeds a two-state issue FSM; a 2-entry R buffer with credit flow control drives the R channel.
module raddr_responder #(
  parameter int DATA_W   = 512,
  parameter int MEM_AW   = 12,
  parameter int AR_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              mem_rd_en,
  output logic [MEM_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy
);

  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int QAW     = $clog2(AR_DEPTH);
  localparam int HI      = MEM_AW + BYTE_SH;

  localparam logic [QAW:0]       AQ_ONE   = {{QAW{1'b0}}, 1'b1};
  localparam logic [MEM_AW-1:0]  WORD_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_BURST} state_e;

  // AR queue holds the already-decoded word address and range-error flag
  logic [MEM_AW-1:0] aq_word_q [AR_DEPTH];
  logic              aq_err_q  [AR_DEPTH];
  logic [7:0]        aq_len_q  [AR_DEPTH];
  logic [QAW:0]      aq_wr_q, aq_rd_q;
  logic              aq_empty, aq_full, aq_push, aq_pop;
  logic [MEM_AW-1:0] head_word;
  logic              head_err;
  logic [7:0]        head_len;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^s_axi_araddr[BYTE_SH-1:0];
  assign aq_empty  = (aq_wr_q == aq_rd_q);
  assign aq_full   = (aq_wr_q[QAW] != aq_rd_q[QAW]) &&
                     (aq_wr_q[QAW-1:0] == aq_rd_q[QAW-1:0]);
  assign aq_push   = s_axi_arvalid && !aq_full;
  assign head_word = aq_word_q[aq_rd_q[QAW-1:0]];
  assign head_err  = aq_err_q[aq_rd_q[QAW-1:0]];
  assign head_len  = aq_len_q[aq_rd_q[QAW-1:0]];
  assign s_axi_arready = !aq_full;

  always_ff @(posedge clk) begin
    if (aq_push) begin
      aq_word_q[aq_wr_q[QAW-1:0]] <= s_axi_araddr[HI-1:BYTE_SH];
      aq_err_q[aq_wr_q[QAW-1:0]]  <= |s_axi_araddr[63:HI];
      aq_len_q[aq_wr_q[QAW-1:0]]  <= s_axi_arlen;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aq_wr_q <= '0;
      aq_rd_q <= '0;
    end else begin
      if (aq_push) aq_wr_q <= aq_wr_q + AQ_ONE;
      if (aq_pop)  aq_rd_q <= aq_rd_q + AQ_ONE;
    end
  end

  // R buffer and the one-cycle SRAM read stage in front of it
  logic [DATA_W-1:0] rb_data_q [2];
  logic [1:0]        rb_resp_q [2];
  logic              rb_last_q [2];
  logic              rb_wr_q, rb_rd_q;
  logic [1:0]        rb_cnt_q;
  logic              infl_q, infl_err_q, infl_last_q;
  logic              rb_push, rb_pop;
  logic [1:0]        used;
  logic              credit;

  assign rb_push = infl_q;
  assign rb_pop  = s_axi_rvalid && s_axi_rready;
  // A beat leaving this cycle frees its slot, which keeps 1 beat/clk sustainable
  assign used    = rb_cnt_q + {1'b0, infl_q} - {1'b0, rb_pop};
  assign credit  = (used < 2'd2);

  assign s_axi_rvalid = (rb_cnt_q != 2'd0);
  assign s_axi_rdata  = s_axi_rvalid ? rb_data_q[rb_rd_q] : '0;
  assign s_axi_rresp  = s_axi_rvalid ? rb_resp_q[rb_rd_q] : 2'b00;
  assign s_axi_rlast  = s_axi_rvalid && rb_last_q[rb_rd_q];

  always_ff @(posedge clk) begin
    if (rb_push) begin
      rb_data_q[rb_wr_q] <= infl_err_q ? '0 : mem_rd_data;
      rb_resp_q[rb_wr_q] <= infl_err_q ? 2'b10 : 2'b00;
      rb_last_q[rb_wr_q] <= infl_last_q;
    end
  end

  // Issue FSM
  state_e            state_q;
  logic [MEM_AW-1:0] wptr_q;
  logic [8:0]        rem_q;
  logic              err_q;
  logic [MEM_AW-1:0] cur_word;
  logic              cur_err, cur_last, have_req, issue;

  always_comb begin
    cur_word = head_word;
    cur_err  = head_err;
    cur_last = (head_len == 8'd0);
    have_req = !aq_empty;
    if (state_q == S_BURST) begin
      cur_word = wptr_q;
      cur_err  = err_q;
      cur_last = (rem_q == 9'd1);
      have_req = 1'b1;
    end
  end

  assign issue       = have_req && credit;
  assign aq_pop      = issue && (state_q == S_IDLE);
  assign mem_rd_en   = issue && !cur_err;
  assign mem_rd_addr = mem_rd_en ? cur_word : '0;
  assign busy        = !aq_empty || (state_q == S_BURST) || infl_q || (rb_cnt_q != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue) begin
            wptr_q <= head_word + WORD_ONE;
            rem_q  <= {1'b0, head_len};
            err_q  <= head_err;
            if (head_len != 8'd0) state_q <= S_BURST;
          end
        end
        S_BURST: begin
          if (issue) begin
            wptr_q <= wptr_q + WORD_ONE;
            rem_q  <= rem_q - 9'd1;
            if (rem_q == 9'd1) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_q      <= 1'b0;
      infl_err_q  <= 1'b0;
      infl_last_q <= 1'b0;
      rb_wr_q     <= 1'b0;
      rb_rd_q     <= 1'b0;
      rb_cnt_q    <= 2'd0;
    end else begin
      infl_q      <= issue;
      infl_err_q  <= cur_err;
      infl_last_q <= cur_last;
      if (rb_push) rb_wr_q <= ~rb_wr_q;
      if (rb_pop)  rb_rd_q <= ~rb_rd_q;
      case ({rb_push, rb_pop})
        2'b10:   rb_cnt_q <= rb_cnt_q + 2'd1;
        2'b01:   rb_cnt_q <= rb_cnt_q - 2'd1;
        default: rb_cnt_q <= rb_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_raddr_responder.sv
// tb/tb_raddr_responder.sv - scoreboard bench for raddr_responder with an SRAM model
// Expected beats are queued at AR acceptance from the burst rules; a negedge monitor pops and compares.
module tb_raddr_responder;

  localparam int DATA_W = 512;
  localparam int MEM_AW = 12;
  localparam int DEPTH  = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [63:0]       s_axi_araddr;
  logic [7:0]        s_axi_arlen;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [DATA_W-1:0] s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rlast;
  logic              s_axi_rvalid;
  logic              s_axi_rready;
  logic              mem_rd_en;
  logic [MEM_AW-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data = '0;
  logic              busy;

  raddr_responder #(.DATA_W(DATA_W), .MEM_AW(MEM_AW), .AR_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  int    beat_cyc_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    last_ar_cyc = 0;
  int    ar_acc = 0;
  int    beats_seen = 0;
  int    rd_en_cnt = 0;
  int    rmode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: a burst reads arlen+1 consecutive SRAM words modulo the SRAM size
  task automatic expect_burst(input logic [63:0] a, input logic [7:0] l);
    logic [MEM_AW-1:0] w;
    logic              err;
    beat_t             b;
    w   = a[MEM_AW+5:6];
    err = (a[63:MEM_AW+6] != '0);
    for (int k = 0; k <= int'(l); k++) begin
      b.data = err ? '0 : mem[(int'(w) + k) % DEPTH];
      b.resp = err ? 2'b10 : 2'b00;
      b.last = (k == int'(l));
      exp_q.push_back(b);
    end
  endtask

  logic              stall_v = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic [1:0]        prev_resp;
  logic              prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_v = 1'b0;
    end else begin
      if (mem_rd_en) rd_en_cnt++;
      if (stall_v) begin
        chk("stall_rvalid", s_axi_rvalid, 1);
        chk("stall_rdata", s_axi_rdata, prev_data);
        chk("stall_rresp", s_axi_rresp, prev_resp);
        chk("stall_rlast", s_axi_rlast, prev_last);
      end
      if (s_axi_arvalid && s_axi_arready) begin
        expect_burst(s_axi_araddr, s_axi_arlen);
        last_ar_cyc = cyc;
        ar_acc++;
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", s_axi_rvalid, 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("rdata", s_axi_rdata, e.data);
          chk("rresp", s_axi_rresp, e.resp);
          chk("rlast", s_axi_rlast, e.last);
        end
        beat_cyc_q.push_back(cyc);
        beats_seen++;
      end
      stall_v   = s_axi_rvalid && !s_axi_rready;
      prev_data = s_axi_rdata;
      prev_resp = s_axi_rresp;
      prev_last = s_axi_rlast;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       s_axi_rready = 1'b1;
        1:       s_axi_rready = ~s_axi_rready;
        2:       s_axi_rready = 1'b0;
        default: s_axi_rready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send_ar(input logic [63:0] a, input logic [7:0] l);
    bit ok;
    ok = 0;
    s_axi_araddr  = a;
    s_axi_arlen   = l;
    s_axi_arvalid = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (s_axi_arready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_axi_arvalid = 1'b0;
    chk("ar_accept", ok, 1);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    chk("drain", ok, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit ok;
    logic [63:0] a;
    rst_n = 1'b0;
    s_axi_araddr = '0;
    s_axi_arlen = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i);
    repeat (3) @(negedge clk);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_rlast", s_axi_rlast, 0);
    chk("rst_rresp", s_axi_rresp, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_mem_rd_addr", mem_rd_addr, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_arready", s_axi_arready, 1);
    @(posedge clk);
    #1;

    // T1: first-beat latency and consecutive beats
    rmode = 0;
    beat_cyc_q.delete();
    send_ar(64'h0, 8'd2);
    wait_drain();
    chk("t1_nbeats", beat_cyc_q.size(), 3);
    if (beat_cyc_q.size() == 3) begin
      chk("t1_lat0", beat_cyc_q[0] - last_ar_cyc, 3);
      chk("t1_lat1", beat_cyc_q[1] - last_ar_cyc, 4);
      chk("t1_lat2", beat_cyc_q[2] - last_ar_cyc, 5);
    end

    // T2: word address wraps 4095 -> 0
    send_ar(64'h3FFC0, 8'd1);
    wait_drain();

    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DATA_W / 32; j++) mem[i][j*32 +: 32] = $urandom;

    // T3: alternating rready over an 8-beat burst
    rmode = 1;
    base = beats_seen;
    send_ar({46'h0, 12'($urandom), 6'($urandom)}, 8'd7);
    wait_drain();
    chk("t3_nbeats", beats_seen - base, 8);

    // T4: queue fills behind a stalled burst
    rmode = 2;
    base = ar_acc;
    send_ar({46'h0, 12'd100, 6'd0}, 8'd7);
    for (int i = 0; i < 4; i++) send_ar({46'h0, 12'($urandom), 6'd0}, 8'($urandom_range(0, 5)));
    chk("t4_accepted", ar_acc - base, 5);
    s_axi_araddr  = {46'h0, 12'd7, 6'd0};
    s_axi_arlen   = 8'd2;
    s_axi_arvalid = 1'b1;
    repeat (20) @(negedge clk);
    chk("t4_full_arready", s_axi_arready, 0);
    chk("t4_no_extra", ar_acc - base, 5);
    @(posedge clk);
    #1;
    rmode = 0;
    send_ar({46'h0, 12'd7, 6'd0}, 8'd2);
    wait_drain();
    chk("t4_total", ar_acc - base, 6);

    // T5: out-of-range address gives SLVERR beats without SRAM reads
    rd_en_cnt = 0;
    base = beats_seen;
    send_ar(64'h1_0000_0000, 8'd3);
    wait_drain();
    chk("t5_no_sram_read", rd_en_cnt, 0);
    chk("t5_nbeats", beats_seen - base, 4);

    // Randomised bursts with random back-pressure, including the length extremes
    rmode = 3;
    for (int i = 0; i < 25; i++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(0, 9) != 0) a[63:MEM_AW+6] = '0;
      send_ar(a, (i == 5) ? 8'd255 : (i == 6) ? 8'd0 : 8'($urandom_range(0, 15)));
    end
    wait_drain();

    // T6: reset in the middle of a burst
    rmode = 0;
    base = beats_seen;
    send_ar({46'h0, 12'd500, 6'd0}, 8'd7);
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (beats_seen - base >= 2) begin
        ok = 1;
        break;
      end
    end
    chk("t6_reach_beat2", ok, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t6_rvalid", s_axi_rvalid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_mem_rd_en", mem_rd_en, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_arready", s_axi_arready, 1);
    chk("t6_busy_after", busy, 0);
    @(posedge clk);
    #1;
    base = beats_seen;
    send_ar({46'h0, 12'd9, 6'd0}, 8'd1);
    wait_drain();
    chk("t6_recover", beats_seen - base, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
